// File: rtl/splitter_1to2_gate_if.sv
// 4-phase req/ack bundled-data channel; the master drives req/data, the slave returns ack.
interface splitter_1to2_gate_if #(
  parameter int unsigned WIDTH = 57
);
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/splitter_1to2_gate.sv
// Clocked 1-to-2 packet splitter: one-entry buffer fed by a 4-phase input channel,
// drained onto out1/out2 according to one destination bit of the packet.
module splitter_1to2_gate #(
  parameter int unsigned WIDTH_packet = 57,
  parameter int unsigned DEST_BIT     = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  splitter_1to2_gate_if.slave     in_ch,
  splitter_1to2_gate_if.master    out1_ch,
  splitter_1to2_gate_if.master    out2_ch,
  output logic [CNT_W-1:0]        cnt1,
  output logic [CNT_W-1:0]        cnt2,
  output logic                    proto_err
);

  typedef enum logic {I_IDLE, I_ACK} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} out_state_t;

  in_state_t               r_in_state,  w_in_state_nxt;
  out_state_t              r_out_state, w_out_state_nxt;

  logic [WIDTH_packet-1:0] r_buf_data,  w_buf_data_nxt;
  logic                    r_buf_valid, w_buf_valid_nxt;
  logic                    r_in_ack,    w_in_ack_nxt;
  logic                    r_port,      w_port_nxt;
  logic                    r_out1_req,  w_out1_req_nxt;
  logic                    r_out2_req,  w_out2_req_nxt;
  logic [WIDTH_packet-1:0] r_out1_data, w_out1_data_nxt;
  logic [WIDTH_packet-1:0] r_out2_data, w_out2_data_nxt;
  logic [CNT_W-1:0]        r_cnt1,      w_cnt1_nxt;
  logic [CNT_W-1:0]        r_cnt2,      w_cnt2_nxt;
  logic                    r_proto_err, w_proto_err_nxt;

  logic w_capture, w_in_release, w_port_ack, w_launch, w_acked, w_done;
  logic w_out_busy, w_err;

  // Handshake events; r_port: 0 -> out1, 1 -> out2
  assign w_capture    = (r_in_state == I_IDLE) && in_ch.req && !r_buf_valid;
  assign w_in_release = (r_in_state == I_ACK) && !in_ch.req;
  assign w_port_ack   = r_port ? out2_ch.ack : out1_ch.ack;
  assign w_launch     = (r_out_state == O_IDLE) && r_buf_valid;
  assign w_acked      = (r_out_state == O_REQ) && w_port_ack;
  assign w_done       = (r_out_state == O_REL) && !w_port_ack;
  assign w_out_busy   = (r_out_state != O_IDLE);
  assign w_err        = (out1_ch.ack && !(w_out_busy && !r_port)) ||
                        (out2_ch.ack && !(w_out_busy &&  r_port));

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_state  <= I_IDLE;
      r_out_state <= O_IDLE;
    end else begin
      r_in_state  <= w_in_state_nxt;
      r_out_state <= w_out_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_in_state_nxt  = r_in_state;
    w_out_state_nxt = r_out_state;
    case (r_in_state)
      I_IDLE:  if (w_capture)    w_in_state_nxt = I_ACK;
      I_ACK:   if (w_in_release) w_in_state_nxt = I_IDLE;
      default: w_in_state_nxt = I_IDLE;
    endcase
    case (r_out_state)
      O_IDLE:  if (w_launch) w_out_state_nxt = O_REQ;
      O_REQ:   if (w_acked)  w_out_state_nxt = O_REL;
      O_REL:   if (w_done)   w_out_state_nxt = O_IDLE;
      default: w_out_state_nxt = O_IDLE;
    endcase
  end

  // Output / datapath next values; buf_valid set and clear never coincide
  always_comb begin
    w_buf_data_nxt  = r_buf_data;
    w_buf_valid_nxt = r_buf_valid;
    w_in_ack_nxt    = r_in_ack;
    w_port_nxt      = r_port;
    w_out1_req_nxt  = r_out1_req;
    w_out2_req_nxt  = r_out2_req;
    w_out1_data_nxt = r_out1_data;
    w_out2_data_nxt = r_out2_data;
    w_cnt1_nxt      = r_cnt1;
    w_cnt2_nxt      = r_cnt2;
    w_proto_err_nxt = r_proto_err | w_err;

    if (w_capture) begin
      w_buf_data_nxt  = in_ch.data;
      w_buf_valid_nxt = 1'b1;
      w_in_ack_nxt    = 1'b1;
    end
    if (w_in_release) w_in_ack_nxt = 1'b0;

    if (w_launch) begin
      w_port_nxt = r_buf_data[DEST_BIT];
      if (r_buf_data[DEST_BIT]) begin
        w_out2_data_nxt = r_buf_data;
        w_out2_req_nxt  = 1'b1;
      end else begin
        w_out1_data_nxt = r_buf_data;
        w_out1_req_nxt  = 1'b1;
      end
    end

    if (w_acked) begin
      if (r_port) w_out2_req_nxt = 1'b0;
      else        w_out1_req_nxt = 1'b0;
    end

    if (w_done) begin
      w_buf_valid_nxt = 1'b0;
      if (r_port) w_cnt2_nxt = r_cnt2 + CNT_W'(1);
      else        w_cnt1_nxt = r_cnt1 + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_data  <= '0;
      r_buf_valid <= 1'b0;
      r_in_ack    <= 1'b0;
      r_port      <= 1'b0;
      r_out1_req  <= 1'b0;
      r_out2_req  <= 1'b0;
      r_out1_data <= '0;
      r_out2_data <= '0;
      r_cnt1      <= '0;
      r_cnt2      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_buf_data  <= w_buf_data_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_in_ack    <= w_in_ack_nxt;
      r_port      <= w_port_nxt;
      r_out1_req  <= w_out1_req_nxt;
      r_out2_req  <= w_out2_req_nxt;
      r_out1_data <= w_out1_data_nxt;
      r_out2_data <= w_out2_data_nxt;
      r_cnt1      <= w_cnt1_nxt;
      r_cnt2      <= w_cnt2_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign in_ch.ack    = r_in_ack;
  assign out1_ch.req  = r_out1_req;
  assign out1_ch.data = r_out1_data;
  assign out2_ch.req  = r_out2_req;
  assign out2_ch.data = r_out2_data;
  assign cnt1         = r_cnt1;
  assign cnt2         = r_cnt2;
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_splitter_1to2_gate.sv
// Randomized bench for splitter_1to2_gate: per-port expected-packet queues and delivery counts.
module tb_splitter_1to2_gate;
  localparam int unsigned W     = 57;
  localparam int unsigned CNT_W = 16;
  localparam int          TMO   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic             proto_err;

  splitter_1to2_gate_if #(.WIDTH(W)) u_in_if ();
  splitter_1to2_gate_if #(.WIDTH(W)) u_out1_if ();
  splitter_1to2_gate_if #(.WIDTH(W)) u_out2_if ();

  splitter_1to2_gate #(.WIDTH_packet(W), .DEST_BIT(0), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_ch     (u_in_if),
    .out1_ch   (u_out1_if),
    .out2_ch   (u_out2_if),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          abort = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int          m_cnt1 = 0;
  int          m_cnt2 = 0;
  int          n_rise1 = 0;
  int          n_rise2 = 0;
  logic        prev1 = 1'b0;
  logic        prev2 = 1'b0;

  // Count rising edges of each output request
  always @(negedge clk) begin
    if (u_out1_if.req === 1'b1 && prev1 !== 1'b1) n_rise1 <= n_rise1 + 1;
    if (u_out2_if.req === 1'b1 && prev2 !== 1'b1) n_rise2 <= n_rise2 + 1;
    prev1 <= u_out1_if.req;
    prev2 <= u_out2_if.req;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_req(input int p);
    return (p == 1) ? u_out1_if.req : u_out2_if.req;
  endfunction

  function automatic logic [W-1:0] get_data(input int p);
    return (p == 1) ? u_out1_if.data : u_out2_if.data;
  endfunction

  function automatic logic [CNT_W-1:0] get_cnt(input int p);
    return (p == 1) ? cnt1 : cnt2;
  endfunction

  function automatic int get_mcnt(input int p);
    return (p == 1) ? m_cnt1 : m_cnt2;
  endfunction

  // s: 0 in_ack, 1 out1_req, 2 out2_req
  function automatic logic sig(input int s);
    case (s)
      0:       return u_in_if.ack;
      1:       return u_out1_if.req;
      default: return u_out2_if.req;
    endcase
  endfunction

  task automatic set_ack(input int p, input logic v);
    if (p == 1) u_out1_if.ack = v;
    else        u_out2_if.ack = v;
  endtask

  task automatic wait_sig(input int s, input logic v, input string tag, output bit ok);
    ok = 1'b0;
    if (abort) return;
    for (int i = 0; i < TMO; i++) begin
      if (sig(s) === v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      abort = 1'b1;
    end
  endtask

  // Offer one packet on the input channel and complete its 4-phase handshake
  task automatic send(input logic [W-1:0] d);
    bit ok;
    if (d[0]) exp_q2.push_back(d);
    else      exp_q1.push_back(d);
    u_in_if.data = d;
    u_in_if.req  = 1'b1;
    @(negedge clk);
    wait_sig(0, 1'b1, "in_ack_rise", ok);
    u_in_if.req = 1'b0;
    @(negedge clk);
    wait_sig(0, 1'b0, "in_ack_fall", ok);
  endtask

  // Accept n packets on port p with a random ack delay
  task automatic consume(input int p, input int n, input int dmin, input int dmax);
    bit           ok;
    logic [W-1:0] e;
    int           dly;
    for (int k = 0; k < n && !abort; k++) begin
      wait_sig(p, 1'b1, "out_req_rise", ok);
      if (!ok) return;
      if (p == 1 && exp_q1.size() > 0)      e = exp_q1.pop_front();
      else if (p == 2 && exp_q2.size() > 0) e = exp_q2.pop_front();
      else begin
        chk("unexpected_pkt", 64'd1, 64'd0);
        e = '0;
      end
      chk((p == 1) ? "out1_data" : "out2_data", 64'(get_data(p)), 64'(e));
      dly = $urandom_range(dmax, dmin);
      repeat (dly) @(negedge clk);
      chk("data_hold", 64'(get_data(p)), 64'(e));
      chk("req_hold", 64'(get_req(p)), 64'd1);
      set_ack(p, 1'b1);
      @(negedge clk);
      wait_sig(p, 1'b0, "out_req_fall", ok);
      set_ack(p, 1'b0);
      if (p == 1) m_cnt1++;
      else        m_cnt2++;
      @(negedge clk);
      chk((p == 1) ? "cnt1" : "cnt2", 64'(get_cnt(p)), 64'(CNT_W'(get_mcnt(p))));
    end
  endtask

  // Single packet with cycle-exact latency checks and 1-cycle ack turnaround
  task automatic route_directed(input int p, input logic [W-1:0] d);
    int other;
    int rises_other;
    other       = 3 - p;
    rises_other = (other == 1) ? n_rise1 : n_rise2;
    u_in_if.data = d;
    u_in_if.req  = 1'b1;
    @(negedge clk);
    chk("lat_in_ack", 64'(u_in_if.ack), 64'd1);
    chk("lat_req_early", 64'(get_req(p)), 64'd0);
    u_in_if.req = 1'b0;
    @(negedge clk);
    chk("lat_out_req", 64'(get_req(p)), 64'd1);
    chk("route_data", 64'(get_data(p)), 64'(d));
    chk("in_ack_fall", 64'(u_in_if.ack), 64'd0);
    set_ack(p, 1'b1);
    @(negedge clk);
    chk("req_fall", 64'(get_req(p)), 64'd0);
    set_ack(p, 1'b0);
    @(negedge clk);
    if (p == 1) m_cnt1++;
    else        m_cnt2++;
    chk("route_cnt", 64'(get_cnt(p)), 64'(CNT_W'(get_mcnt(p))));
    chk("other_cnt", 64'(get_cnt(other)), 64'(CNT_W'(get_mcnt(other))));
    @(negedge clk);
    chk("other_req_quiet", 64'((other == 1) ? n_rise1 : n_rise2), 64'(rises_other));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ok;
    bit           early;
    int           base2;
    int           base1s, base2s;
    logic [W-1:0] a, b;

    rst           = 1'b1;
    u_in_if.req   = 1'b0;
    u_in_if.data  = '0;
    u_out1_if.ack = 1'b0;
    u_out2_if.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ack", 64'(u_in_if.ack), 64'd0);
    chk("rst_out1_req", 64'(u_out1_if.req), 64'd0);
    chk("rst_out2_req", 64'(u_out2_if.req), 64'd0);
    chk("rst_cnt", 64'({cnt1, cnt2}), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    route_directed(1, 57'h0AA);
    route_directed(2, 57'h155);
    chk("out1_data_kept", 64'(u_out1_if.data), 64'h0AA);

    // Backpressure: out2 withholds ack for 20 cycles while a second packet waits
    a     = W'(64'h1234_5678_9ABC_DEF1);
    b     = W'(64'h0FED_CBA9_8765_4323);
    base2 = m_cnt2;
    early = 1'b0;
    fork
      begin send(a); send(b); end
      begin consume(2, 1, 20, 20); consume(2, 1, 1, 2); end
      begin
        wait_sig(2, 1'b1, "bp_out2_req", ok);
        for (int i = 0; i < TMO && m_cnt2 == base2 && !abort; i++) begin
          if (u_in_if.ack === 1'b1) early = 1'b1;
          @(negedge clk);
        end
        chk("bp_in_ack_held", 64'(early), 64'd0);
      end
    join
    chk("bp_delivered", 64'(m_cnt2 - base2), 64'd2);

    // Stream of alternating destinations
    base1s = m_cnt1;
    base2s = m_cnt2;
    fork
      begin
        for (int i = 0; i < 200 && !abort; i++) begin
          logic [W-1:0] d;
          d    = W'({$urandom(), $urandom()});
          d[0] = (i % 2 == 1);
          send(d);
          repeat ($urandom_range(2, 0)) @(negedge clk);
        end
      end
      consume(1, 100, 0, 4);
      consume(2, 100, 0, 4);
    join
    repeat (2) @(negedge clk);
    chk("stream_n1", 64'(m_cnt1 - base1s), 64'd100);
    chk("stream_n2", 64'(m_cnt2 - base2s), 64'd100);
    chk("stream_cnt1", 64'(cnt1), 64'(CNT_W'(m_cnt1)));
    chk("stream_cnt2", 64'(cnt2), 64'(CNT_W'(m_cnt2)));
    chk("queues_empty", 64'(exp_q1.size() + exp_q2.size()), 64'd0);

    // Spurious ack on out1 while out2 is the active port
    chk("perr_clear", 64'(proto_err), 64'd0);
    fork
      send(W'(57'h0_5A5A_0F0F));
      consume(2, 1, 6, 6);
      begin
        wait_sig(2, 1'b1, "sp_req", ok);
        @(negedge clk);
        u_out1_if.ack = 1'b1;
        @(negedge clk);
        u_out1_if.ack = 1'b0;
        @(negedge clk);
        chk("perr_set", 64'(proto_err), 64'd1);
      end
    join
    repeat (3) @(negedge clk);
    chk("perr_sticky", 64'(proto_err), 64'd1);
    chk("sp_cnt1", 64'(cnt1), 64'(CNT_W'(m_cnt1)));

    // Asynchronous reset in the middle of an out1 request
    fork
      send(W'(57'h0_00C0_FFEE));
      begin
        wait_sig(1, 1'b1, "rst_req", ok);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ack", 64'(u_in_if.ack), 64'd0);
        chk("arst_out1_req", 64'(u_out1_if.req), 64'd0);
        chk("arst_out1_data", 64'(u_out1_if.data), 64'd0);
        chk("arst_cnt", 64'({cnt1, cnt2}), 64'd0);
        chk("arst_perr", 64'(proto_err), 64'd0);
      end
    join
    exp_q1.delete();
    exp_q2.delete();
    m_cnt1 = 0;
    m_cnt2 = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out1_req", 64'(u_out1_if.req), 64'd0);
    fork
      send(W'(57'h0_0000_0042));
      consume(1, 1, 0, 2);
    join
    chk("post_rst_cnt2", 64'(cnt2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
